// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared FSM states, PC constants and instruction field positions
package instr_fetch_unit_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_e;
    localparam logic [15:0] PC_RESET = 16'h0000;
    localparam logic [15:0] PC_STEP  = 16'd2;
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 11;
    localparam int FLAG_BIT = 10;
    localparam int IMM_MSB  = 9;
endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// pc_register: program counter with next-PC mux (hold, PC+2, or branch target)
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   advance_i    : retire current instruction, update PC this edge
//   load_i       : take target_i instead of PC+2 when advancing
//   target_i     : branch/jump target, bit 0 forced low
//   pc_o         : current program counter
module pc_register
    import instr_fetch_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        advance_i,
    input  logic        load_i,
    input  logic [15:0] target_i,
    output logic [15:0] pc_o
);
    logic [15:0] pc_q, pc_d;

    // PC+2 wraps naturally in 16 bits; targets are halfword aligned
    always_comb begin
        pc_d = advance_i ? (load_i ? (target_i & 16'hFFFE) : pc_q + PC_STEP) : pc_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pc_q <= PC_RESET;
        else         pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch/decode/exec sequencer holding IR and driving instruction memory
//   CLK, RESET_N          : clock, asynchronous active-low reset
//   MemData, MemReady     : instruction memory response
//   PCIn, PCWrite, Stall  : branch target, branch request, retire hold from datapath
//   IMemAddr, IMemReq     : instruction memory request
//   OPCODE, flagbit, Immediate, InstrValid : decoded fields of IR and their qualifier
//   PC                    : address of the instruction held in IR
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] MemData,
    input  logic        MemReady,
    input  logic [15:0] PCIn,
    input  logic        PCWrite,
    input  logic        Stall,
    output logic [15:0] IMemAddr,
    output logic        IMemReq,
    output logic [4:0]  OPCODE,
    output logic        flagbit,
    output logic [9:0]  Immediate,
    output logic        InstrValid,
    output logic [15:0] PC
);
    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        pc_advance;

    // MemReady is only honoured in FETCH; PC only moves when EXEC retires
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_advance = 1'b0;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (MemReady) begin
                         ir_d    = MemData;
                         state_d = DECODE;
                     end
            DECODE:  state_d = EXEC;
            EXEC:    if (!Stall) begin
                         pc_advance = 1'b1;
                         state_d    = FETCH;
                     end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    pc_register u_pc (
        .clk_i     (CLK),
        .rst_ni    (RESET_N),
        .advance_i (pc_advance),
        .load_i    (PCWrite),
        .target_i  (PCIn),
        .pc_o      (PC)
    );

    // Decoded from registered state so reset drops them without waiting for a clock
    assign IMemReq    = (state_q == FETCH);
    assign InstrValid = (state_q == DECODE) || (state_q == EXEC);
    assign IMemAddr   = PC;
    assign OPCODE     = ir_q[OPC_MSB:OPC_LSB];
    assign flagbit    = ir_q[FLAG_BIT];
    assign Immediate  = ir_q[IMM_MSB:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven fetch/decode/exec checks with a decode scoreboard
module tb_instr_fetch_unit;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] MemData = 16'h0000;
    logic        MemReady = 1'b0;
    logic [15:0] PCIn = 16'h0000;
    logic        PCWrite = 1'b0;
    logic        Stall = 1'b0;
    logic [15:0] IMemAddr;
    logic        IMemReq;
    logic [4:0]  OPCODE;
    logic        flagbit;
    logic [9:0]  Immediate;
    logic        InstrValid;
    logic [15:0] PC;

    instr_fetch_unit dut (
        .CLK(CLK), .RESET_N(RESET_N), .MemData(MemData), .MemReady(MemReady),
        .PCIn(PCIn), .PCWrite(PCWrite), .Stall(Stall), .IMemAddr(IMemAddr),
        .IMemReq(IMemReq), .OPCODE(OPCODE), .flagbit(flagbit), .Immediate(Immediate),
        .InstrValid(InstrValid), .PC(PC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] data;
        int          mwait;
        int          stall;
        logic        pw;
        logic [15:0] pcin;
        logic [15:0] exp_addr;
        logic [4:0]  opc;
        logic        flag;
        logic [9:0]  imm;
        logic [15:0] exp_next;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [4:0]  opc;
        logic        flag;
        logic [9:0]  imm;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at a falling edge with the DUT in FETCH; leaves at the falling edge of the next FETCH
    task automatic run_vec(input vec_t v);
        exp_t e;
        chk("fetch_req", IMemReq, 1);
        chk("fetch_addr", IMemAddr, v.exp_addr);
        chk("fetch_valid", InstrValid, 0);
        for (int w = 0; w < v.mwait; w++) begin
            MemReady = 1'b0;
            MemData  = 16'hDEAD;
            @(negedge CLK);
            chk("wait_req", IMemReq, 1);
            chk("wait_addr", IMemAddr, v.exp_addr);
            chk("wait_valid", InstrValid, 0);
        end
        MemReady = 1'b1;
        MemData  = v.data;
        sb.push_back('{v.exp_addr, v.opc, v.flag, v.imm});
        @(negedge CLK);
        // Outside FETCH these must all be ignored
        MemData = ~v.data;
        PCWrite = 1'b1;
        PCIn    = 16'h4444;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_empty at %0t", $time);
            e = '{16'h0, 5'h0, 1'b0, 10'h0};
        end else begin
            e = sb.pop_front();
        end
        chk("dec_valid", InstrValid, 1);
        chk("dec_req", IMemReq, 0);
        chk("dec_opc", OPCODE, e.opc);
        chk("dec_flag", flagbit, e.flag);
        chk("dec_imm", Immediate, e.imm);
        chk("dec_pc", PC, e.pc);
        @(negedge CLK);
        chk("exec_valid", InstrValid, 1);
        chk("exec_opc", OPCODE, e.opc);
        for (int s = 0; s < v.stall; s++) begin
            Stall   = 1'b1;
            PCWrite = (s == 0);
            PCIn    = 16'h8888;
            @(negedge CLK);
            chk("stall_valid", InstrValid, 1);
            chk("stall_imm", Immediate, e.imm);
            chk("stall_flag", flagbit, e.flag);
            chk("stall_pc", PC, e.pc);
        end
        Stall   = 1'b0;
        PCWrite = v.pw;
        PCIn    = v.pcin;
        @(negedge CLK);
        chk("next_valid", InstrValid, 0);
        chk("next_req", IMemReq, 1);
        chk("next_addr", IMemAddr, v.exp_next);
        chk("next_opc_kept", OPCODE, e.opc);
        PCWrite  = 1'b0;
        MemReady = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int cyc;
        vecs[0] = '{16'h0400, 0, 0, 1'b0, 16'h0000, 16'h0000, 5'd0,  1'b1, 10'h000, 16'h0002};
        vecs[1] = '{16'hF9AB, 5, 0, 1'b1, 16'h1235, 16'h0002, 5'd31, 1'b0, 10'h1AB, 16'h1234};
        vecs[2] = '{16'h5A5A, 0, 3, 1'b0, 16'h0000, 16'h1234, 5'd11, 1'b0, 10'h25A, 16'h1236};
        vecs[3] = '{16'h8001, 1, 1, 1'b1, 16'hFFFF, 16'h1236, 5'd16, 1'b0, 10'h001, 16'hFFFE};
        vecs[4] = '{16'h07FF, 0, 0, 1'b0, 16'h0000, 16'hFFFE, 5'd0,  1'b1, 10'h3FF, 16'h0000};
        vecs[5] = '{16'hFFFF, 2, 0, 1'b0, 16'h0000, 16'h0000, 5'd31, 1'b1, 10'h3FF, 16'h0002};

        MemReady = 1'b1;
        MemData  = 16'hFFFF;
        repeat (2) @(negedge CLK);
        chk("rst_req", IMemReq, 0);
        chk("rst_valid", InstrValid, 0);
        chk("rst_opc", OPCODE, 0);
        chk("rst_pc", PC, 16'h0000);
        MemReady = 1'b0;
        RESET_N  = 1'b1;
        #1;
        chk("idle_req", IMemReq, 0);
        cyc = 0;
        while (!IMemReq && cyc < 8) begin
            @(negedge CLK);
            cyc++;
        end
        chk("idle_len", cyc, 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset mid-FETCH while memory answers in the same cycle
        MemReady = 1'b1;
        MemData  = 16'hFFFF;
        #2 RESET_N = 1'b0;
        #1;
        chk("mid_rst_req", IMemReq, 0);
        chk("mid_rst_valid", InstrValid, 0);
        chk("mid_rst_opc", OPCODE, 0);
        chk("mid_rst_flag", flagbit, 0);
        chk("mid_rst_imm", Immediate, 0);
        chk("mid_rst_pc", PC, 16'h0000);
        @(negedge CLK);
        chk("rst_hold_imm", Immediate, 0);
        RESET_N = 1'b1;
        #1;
        chk("rel_idle_req", IMemReq, 0);
        @(negedge CLK);
        chk("rel_fetch_req", IMemReq, 1);
        chk("rel_fetch_addr", IMemAddr, 16'h0000);
        chk("rel_ir_clear", OPCODE, 0);
        MemReady = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
